// File: rtl/lab2_proc_imm_encoder_if.sv
// Request/response bundle for the immediate encoder.
//   Request  : in_val/in_rdy handshake, in_imm_type, in_imm, in_base
//   Response : out_val/out_rdy handshake, out_inst, out_err
// master : the client issuing requests and consuming responses
// slave  : the encoder itself
interface lab2_proc_imm_encoder_if;
  logic        in_val;
  logic        in_rdy;
  logic [2:0]  in_imm_type;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_inst;
  logic        out_err;

  modport master (
    output in_val, in_imm_type, in_imm, in_base, out_rdy,
    input  in_rdy, out_val, out_inst, out_err
  );

  modport slave (
    input  in_val, in_imm_type, in_imm, in_base, out_rdy,
    output in_rdy, out_val, out_inst, out_err
  );
endinterface

// File: rtl/lab2_proc_imm_encoder.sv
// Inverse of the TinyRV2 immediate generator: scatters an immediate into the
// immediate fields of an instruction template and flags values that the
// selected format cannot represent.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous active-low reset
//   bus        request/response handshake bundle (slave side)
//   err_count  saturating count of delivered responses with out_err=1
//
// Two-stage elastic pipeline:
//   S1 holds the raw request; range check and field insertion are computed
//      combinationally from S1.
//   S2 holds the finished instruction and error bit and drives the outputs.
// in_rdy depends on out_rdy only, never on in_val, so no input-to-output
// combinational path exists.
module lab2_proc_imm_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  lab2_proc_imm_encoder_if.slave bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] TYPE_I     = 3'd0;
  localparam logic [2:0] TYPE_S     = 3'd1;
  localparam logic [2:0] TYPE_B     = 3'd2;
  localparam logic [2:0] TYPE_U     = 3'd3;
  localparam logic [2:0] TYPE_J     = 3'd4;
  localparam logic [2:0] TYPE_SHAMT = 3'd5;

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // True when every bit of the slice is identical, i.e. the value fits the
  // narrower signed field once the upper bits are dropped.
  function automatic logic all_same21(input logic [20:0] v);
    return (&v) || (~|v);
  endfunction

  function automatic logic all_same20(input logic [19:0] v);
    return (&v) || (~|v);
  endfunction

  function automatic logic all_same12(input logic [11:0] v);
    return (&v) || (~|v);
  endfunction

  function automatic logic imm_bad(input logic [2:0] t, input logic [31:0] imm);
    logic bad;
    bad = 1'b1;
    case (t)
      TYPE_I, TYPE_S: bad = !all_same21(imm[31:11]);
      TYPE_B:         bad = imm[0] || !all_same20(imm[31:12]);
      TYPE_U:         bad = |imm[11:0];
      TYPE_J:         bad = imm[0] || !all_same12(imm[31:20]);
      TYPE_SHAMT:     bad = |imm[31:5];
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] imm_insert(input logic [2:0]  t,
                                             input logic [31:0] imm,
                                             input logic [31:0] base);
    logic [31:0] inst;
    inst = base;
    case (t)
      TYPE_I: begin
        inst[31:20] = imm[11:0];
      end
      TYPE_S: begin
        inst[31:25] = imm[11:5];
        inst[11:7]  = imm[4:0];
      end
      TYPE_B: begin
        inst[31]    = imm[12];
        inst[30:25] = imm[10:5];
        inst[11:8]  = imm[4:1];
        inst[7]     = imm[11];
      end
      TYPE_U: begin
        inst[31:12] = imm[31:12];
      end
      TYPE_J: begin
        inst[31]    = imm[20];
        inst[30:21] = imm[10:1];
        inst[20]    = imm[11];
        inst[19:12] = imm[19:12];
      end
      TYPE_SHAMT: begin
        // funct7 in [31:25] stays from the template (srai vs srli)
        inst[24:20] = imm[4:0];
      end
      default: begin
        inst = base;
      end
    endcase
    return inst;
  endfunction

  // Stage S1: captured request
  logic        s1_val;
  logic [2:0]  s1_type;
  logic [31:0] s1_imm;
  logic [31:0] s1_base;

  // Stage S2: encoded response
  logic        s2_val;
  logic [31:0] s2_inst;
  logic        s2_err;

  logic        s2_advance;
  logic        s1_advance;
  logic        in_xfer;
  logic        out_xfer;
  logic        s1_err;
  logic [31:0] s1_inst;

  always_comb begin
    s2_advance = !s2_val || bus.out_rdy;
    s1_advance = !s1_val || s2_advance;
    in_xfer    = bus.in_val && s1_advance;
    out_xfer   = s2_val && bus.out_rdy;
  end

  always_comb begin
    s1_err  = imm_bad(s1_type, s1_imm);
    s1_inst = s1_err ? s1_base : imm_insert(s1_type, s1_imm, s1_base);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_val  <= 1'b0;
      s1_type <= '0;
      s1_imm  <= '0;
      s1_base <= '0;
    end else if (s1_advance) begin
      s1_val <= bus.in_val;
      if (bus.in_val) begin
        s1_type <= bus.in_imm_type;
        s1_imm  <= bus.in_imm;
        s1_base <= bus.in_base;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_val  <= 1'b0;
      s2_inst <= '0;
      s2_err  <= 1'b0;
    end else if (s2_advance) begin
      s2_val <= s1_val;
      if (s1_val) begin
        s2_inst <= s1_inst;
        s2_err  <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (out_xfer && s2_err && (err_count != ERR_CNT_MAX)) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign bus.in_rdy   = s1_advance;
  assign bus.out_val  = s2_val;
  assign bus.out_inst = s2_inst;
  assign bus.out_err  = s2_err;

  // in_xfer is kept for readability of the handshake; fold it into nothing
  // observable so it does not dangle.
  logic unused_ok;
  assign unused_ok = in_xfer;

endmodule

// File: tb/tb_lab2_proc_imm_encoder.sv
module tb_lab2_proc_imm_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] err_count;
  int         rdy_mode = 1;   // 0: out_rdy low, 1: high, 2: random
  int         n_checks = 0;
  int         n_fail   = 0;
  int         accepted = 0;
  logic [32:0] exp_q[$];      // {err, inst}

  lab2_proc_imm_encoder_if bus ();

  lab2_proc_imm_encoder #(.ERR_CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_rdy = 1'b0;
      1:       bus.out_rdy = 1'b1;
      default: bus.out_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer.
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset && bus.out_val === 1'b1 && bus.out_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got inst 0x%08h with empty scoreboard at %0t",
                 bus.out_inst, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_inst", bus.out_inst, e[31:0]);
        chk("out_err", 32'(bus.out_err), 32'(e[32]));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] t, input logic [31:0] imm,
                      input logic [31:0] base, input logic [31:0] exp_inst,
                      input logic exp_err);
    int  waited;
    bit  done;
    waited = 0;
    done   = 0;
    bus.in_val      = 1'b1;
    bus.in_imm_type = t;
    bus.in_imm      = imm;
    bus.in_base     = base;
    while (!done) begin
      @(negedge clk);
      if (bus.in_rdy) begin
        exp_q.push_back({exp_err, exp_inst});
        accepted++;
        done = 1;
      end else if (++waited > 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_rdy stuck low, got 0 expected 1");
        done = 1;
      end
    end
    @(posedge clk);
    #1;
    bus.in_val = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 400) begin
      @(posedge clk);
      waited++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  typedef struct {
    logic [2:0]  t;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t good_vecs[6];
  vec_t err_vecs[3];
  vec_t bp_vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    good_vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0};
    good_vecs[1] = '{3'd1, 32'h0000_0008, 32'h0000_2023, 32'h0000_2423, 1'b0};
    good_vecs[2] = '{3'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0};
    good_vecs[3] = '{3'd3, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0};
    good_vecs[4] = '{3'd4, 32'h0000_0008, 32'h0000_006F, 32'h0080_006F, 1'b0};
    good_vecs[5] = '{3'd5, 32'h0000_0003, 32'h4000_5013, 32'h4030_5013, 1'b0};
    err_vecs[0]  = '{3'd0, 32'h0000_0800, 32'h0000_0013, 32'h0000_0013, 1'b1};
    err_vecs[1]  = '{3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0063, 1'b1};
    err_vecs[2]  = '{3'd7, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b1};
    bp_vecs[0]   = '{3'd0, 32'd1, 32'h0000_0013, 32'h0010_0013, 1'b0};
    bp_vecs[1]   = '{3'd0, 32'd2, 32'h0000_0013, 32'h0020_0013, 1'b0};
    bp_vecs[2]   = '{3'd0, 32'd3, 32'h0000_0013, 32'h0030_0013, 1'b0};
    bp_vecs[3]   = '{3'd0, 32'd4, 32'h0000_0013, 32'h0040_0013, 1'b0};
    bp_vecs[4]   = '{3'd0, 32'd5, 32'h0000_0013, 32'h0050_0013, 1'b0};

    bus.in_val      = 1'b0;
    bus.in_imm_type = '0;
    bus.in_imm      = '0;
    bus.in_base     = '0;
    bus.out_rdy     = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_val", 32'(bus.out_val), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'h0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_rdy", 32'(bus.in_rdy), 32'd1);

    // Latency: accepted at edge N, valid only after edge N+1.
    send(good_vecs[0].t, good_vecs[0].imm, good_vecs[0].base, good_vecs[0].inst, good_vecs[0].err);
    @(negedge clk);
    chk("latency_n", 32'(bus.out_val), 32'd0);
    @(negedge clk);
    chk("latency_n1", 32'(bus.out_val), 32'd1);
    @(posedge clk);
    #1;
    drain();

    for (int i = 1; i < 6; i++)
      send(good_vecs[i].t, good_vecs[i].imm, good_vecs[i].base, good_vecs[i].inst, good_vecs[i].err);
    drain();
    chk("err_count_clean", 32'(err_count), 32'd0);

    for (int i = 0; i < 3; i++)
      send(err_vecs[i].t, err_vecs[i].imm, err_vecs[i].base, err_vecs[i].inst, err_vecs[i].err);
    drain();
    chk("err_count_3", 32'(err_count), 32'd3);

    for (int i = 0; i < 300; i++)
      send(3'd6, 32'(i), 32'h0000_00B3, 32'h0000_00B3, 1'b1);
    drain();
    chk("err_count_sat", 32'(err_count), 32'd255);

    // Backpressure: only two requests fit while out_rdy is low.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    begin
      int base_acc;
      base_acc = accepted;
      fork
        begin
          for (int i = 0; i < 5; i++)
            send(bp_vecs[i].t, bp_vecs[i].imm, bp_vecs[i].base, bp_vecs[i].inst, bp_vecs[i].err);
        end
        begin
          repeat (6) @(negedge clk);
          chk("bp_accepted", 32'(accepted - base_acc), 32'd2);
          chk("bp_in_rdy", 32'(bus.in_rdy), 32'd0);
          chk("bp_out_val", 32'(bus.out_val), 32'd1);
          rdy_mode = 1;
        end
      join
    end
    drain();

    // Random out_rdy against the scoreboard order.
    rdy_mode = 2;
    for (int k = 1; k <= 20; k++)
      send(3'd3, 32'(k) << 12, 32'h0000_0037, (32'(k) << 12) | 32'h0000_0037, 1'b0);
    rdy_mode = 1;
    drain();

    // Asynchronous reset with two items buffered.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(good_vecs[3].t, good_vecs[3].imm, good_vecs[3].base, good_vecs[3].inst, good_vecs[3].err);
    send(good_vecs[4].t, good_vecs[4].imm, good_vecs[4].base, good_vecs[4].inst, good_vecs[4].err);
    @(negedge clk);
    chk("pre_rst_out_val", 32'(bus.out_val), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("async_rst_out_val", 32'(bus.out_val), 32'd0);
    chk("async_rst_err_count", 32'(err_count), 32'd0);
    chk("async_rst_out_inst", bus.out_inst, 32'h0);
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("post_rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    repeat (5) @(negedge clk);
    chk("post_rst_no_stale", 32'(bus.out_val), 32'd0);
    @(posedge clk);
    #1;
    send(good_vecs[2].t, good_vecs[2].imm, good_vecs[2].base, good_vecs[2].inst, good_vecs[2].err);
    drain();
    chk("final_err_count", 32'(err_count), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lab2_proc_imm_encoder.md
Name: lab2_proc_imm_encoder

Overview:
Pipelined inverse of the processor's immediate generator. It takes a 32-bit instruction template and a 32-bit immediate value with an immediate type. It inserts the immediate bits into the template in TinyRV2 field positions and flags immediates that cannot be represented. It serves as the instruction-assembly engine for self-checking test sources and the trace/debug path. It has latency-insensitive val/rdy interfaces on both sides, a 2-stage elastic pipeline, and a saturating error counter.

Parameters:
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
in_val  input  1  request valid
in_rdy  output  1  request ready
in_imm_type  input  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=shamt; 6,7 invalid
in_imm  input  32  immediate value (sign-extended, byte-offset form)
in_base  input  32  instruction template; opcode/rd/rs/funct bits used as-is
out_val  output  1  response valid
out_rdy  input  1  response ready
out_inst  output  32  encoded instruction
out_err  output  1  immediate not representable / invalid type
err_count  output  ERR_CNT_W  number of erroneous responses delivered, saturating

Behaviour:
- Transfers happen only on a cycle where val && rdy on that interface. Requests and responses are strictly in order, one response per request.
- Stage S1 captures type, imm and base on an input transfer and computes the range check.
- Stage S2 holds the encoded instruction and error bit, and drives out_*.
- S2 advances when out_val=0 or out_rdy=1.
- S1 advances when S1 is empty or S2 advances.
- in_rdy = !s1_val || s1_advance. It is combinational from out_rdy; no combinational path exists from in_val to out_*.
- Minimum latency is 2 cycles: accepted at edge N, out_val high after edge N+1. Full throughput is 1 per cycle with out_rdy held high. With out_rdy low, at most 2 requests are buffered.
- Range check (err=1 when violated):
  - I, S: imm[31:11] all equal.
  - B: imm[0]==0 and imm[31:12] all equal.
  - U: imm[11:0]==0.
  - J: imm[0]==0 and imm[31:20] all equal.
  - shamt: imm[31:5]==0.
  - types 6,7: always err.
- Encoding (bits not listed are taken from in_base):
  - I: inst[31:20]=imm[11:0].
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
  - B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11].
  - U: inst[31:12]=imm[31:12].
  - J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12].
  - shamt: inst[24:20]=imm[4:0]; inst[31:25] kept from base (funct7).
- On err=1: out_inst = in_base unmodified, out_err=1.
- err_count increments on each output transfer with out_err=1 and holds at all-ones (no wrap).
- Reset (reset=0, asynchronous):
  - all valid bits clear, so out_val=0 and in_rdy=1 after release.
  - out_inst=0, out_err=0, err_count=0.
  - in-flight requests are discarded; no response is produced for them.
- Simultaneous input and output transfer with both stages full: S2 drains, S1 moves to S2, new request enters S1 in the same edge.

Test Plan:
- I-type: type=0, imm=0xFFFFFFFF, base=0x00000013 → out_inst=0xFFF00013, err=0, out_val exactly 2 cycles after acceptance.
- S and B:
  - type=1, imm=8, base=0x00002023 → 0x00002423.
  - type=2, imm=0xFFFFFFFC, base=0x00000063 → 0xFE000EE3.
- U, J, shamt:
  - type=3, imm=0x12345000, base=0x00000037 → 0x12345037.
  - type=4, imm=0x00000008, base=0x0000006F → 0x0080006F.
  - type=5, imm=3, base=0x40005013 → 0x40305013.
- Errors and counter:
  - type=0, imm=2048 → out_inst=base, err=1.
  - type=2, imm=3 → err=1.
  - type=7 → err=1.
  - err_count=3 after those; 300 errors with ERR_CNT_W=8 → err_count=255.
- Backpressure: out_rdy=0 while streaming 5 back-to-back requests → in_rdy falls after 2 accepted. Releasing out_rdy delivers all 5 in order with no duplicates or losses; random out_rdy toggling is checked against a reference queue.
- Reset: assert reset mid-stream with 2 items buffered → out_val=0 and err_count=0 immediately (asynchronous). No stale response appears after release; the next request encodes correctly.
